load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the core's data-memory port: turns core load/store requests (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into word-addressed memory accesses with a 4-bit byte-write mask and a read enable.
- Lane-aligns store data, extracts and sign/zero-extends load data, and detects misaligned or illegal accesses.
- Sits between the execute stage and the data memory, with a req/busy/done handshake toward the core.

Parameters:
- WORD_W, 32, data and address width (matches `WORD_SIZE+1).
- SPLIT_UPPER_HALF, 1, when 1, SH to byte offset 2 is issued as two single-byte writes (mask 0100 then 1000). The memory mask set is 1111, 0111, 0011 and single bytes; 1100 is not a supported mask.

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_req  in  1  request strobe; sampled only in IDLE
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32I width/sign code
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-justified
- o_busy  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done; misaligned or illegal funct3
- o_rdata  out  32  extended load data; held until next load completes
- o_mem_addr  out  32  byte address to memory; bits [1:0] forced to 0
- o_mem_wd  out  32  lane-replicated write data
- o_mem_wen  out  4  byte-write mask
- o_mem_ren  out  1  read enable
- i_mem_rd  in  32  memory read word, valid the cycle after the ren edge

Behaviour:
- Reset (async, i_rstn=0): state=IDLE. All outputs are 0, including o_rdata, o_mem_wen and o_mem_ren.
- Outputs: all are registered. o_busy is decoded from the state register.
- States: IDLE, ACCESS, WR_HI, RD_WAIT, RESP.
- IDLE + i_req (edge E0): capture funct3, addr and wdata, then check legality.
  - Loads: funct3 in {000,001,010,100,101} is legal.
  - Stores: funct3 in {000,001,010} is legal.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Illegal or misaligned: go to RESP with o_err=1. No memory signal asserts.
- Legal: go to ACCESS. Memory outputs are registered at E0.
  - Load: ren=1, wen=0000.
  - SB: wen = 0001 << addr[1:0], wd = {4{byte}}.
  - SH at offset 0: wen = 0011, wd = {2{half}}.
  - SH at offset 2: if SPLIT_UPPER_HALF, wen = 0100; otherwise wen = 1100.
  - SW: wen = 1111, wd = wdata.
- ACCESS (memory samples at E1):
  - Store, split case: go to WR_HI with wen=1000 and the same wd/addr.
  - Store, all other cases: go to RESP, clear wen, set o_done=1.
  - Load: clear ren, go to RD_WAIT.
- WR_HI (edge E2): clear wen, go to RESP, set o_done=1.
- RD_WAIT: i_mem_rd is valid.
  - Select byte lane addr[1:0] or half lane addr[1].
  - Sign-extend for 000/001; zero-extend for 100/101.
  - Register the result into o_rdata, set o_done=1, go to RESP.
- RESP: clear o_done and o_err, return to IDLE. A new i_req is accepted the cycle after RESP.
- Latency from the request cycle to the o_done-high cycle:
  - Store: 2 cycles.
  - Split SH: 3 cycles.
  - Load: 3 cycles.
  - Error: 1 cycle.
- i_req while busy: ignored and not queued. The core must hold it until it sees o_busy=0.
- o_mem_ren and o_mem_wen are never both nonzero.
- o_rdata is updated only by successful loads. Stores and errors leave it unchanged.
- Reset mid-operation: outputs clear immediately and no o_done is produced. A split SH may leave only byte 2 written; this is the decided behaviour.

Decomposition:
- Shared package/defines header:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding.
  - WEN_* mask constants.
- Sub-module load_extend: purely combinational lane select plus sign/zero extension (i_mem_rd, addr[1:0], funct3 → 32-bit).

Test Plan:
- Memory word at 0x10 = 0x8899AABB.
  - LB 0x11 → ren one cycle, o_rdata=0xFFFFFFAA, o_done 3 cycles after req.
  - LBU 0x13 → o_rdata=0x00000088.
- LH 0x12 → o_rdata=0xFFFF8899. LHU 0x10 → o_rdata=0x0000AABB. LW 0x10 → o_rdata=0x8899AABB.
- SH 0x12, wdata=0x00001234 → wd=0x12341234, wen 0100 then 1000 on consecutive cycles; word reads back 0x1234AABB; o_done 3 cycles after req.
- SB 0x13 with 0x000000EE → wen=1000, wd=0xEEEEEEEE. SW 0x10 with 0xDEADBEEF → wen=1111, o_done 2 cycles after req, no ren.
- LW 0x11 → o_err=1 and o_done=1 one cycle after req; wen and ren stay 0; o_rdata unchanged. Load funct3=011 → same error response.
- Reset and back-to-back:
  - i_rstn low during WR_HI of a split SH → all outputs 0 at once, IDLE, no o_done.
  - i_req held high across a busy LW → second request accepted only after RESP.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM state encoding, byte-write masks and the access legality check.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_B0   = 4'b0001;
  localparam logic [3:0] WEN_B2   = 4'b0100;
  localparam logic [3:0] WEN_B3   = 4'b1000;
  localparam logic [3:0] WEN_LO   = 4'b0011;
  localparam logic [3:0] WEN_HI   = 4'b1100;
  localparam logic [3:0] WEN_ALL  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_WR_HI   = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  // Unsigned widths exist only for loads; halfwords need even, words 4-byte alignment.
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic legal;
    logic aligned;
    case (f3)
      F3_B:    begin legal = 1'b1; aligned = 1'b1;          end
      F3_H:    begin legal = 1'b1; aligned = ~off[0];       end
      F3_W:    begin legal = 1'b1; aligned = (off == 2'b00); end
      F3_BU:   begin legal = ~we;  aligned = 1'b1;          end
      F3_HU:   begin legal = ~we;  aligned = ~off[0];       end
      default: begin legal = 1'b0; aligned = 1'b1;          end
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load-data path: picks the addressed byte/half lane from the
// memory word and sign- or zero-extends it according to funct3.
module load_extend
  import load_store_unit_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] i_mem_rd,
  input  logic [1:0]        i_off,
  input  logic [2:0]        i_funct3,
  output logic [WORD_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by extension.
  always_comb begin
    case (i_off)
      2'b00:   w_byte = i_mem_rd[7:0];
      2'b01:   w_byte = i_mem_rd[15:8];
      2'b10:   w_byte = i_mem_rd[23:16];
      2'b11:   w_byte = i_mem_rd[31:24];
      default: w_byte = i_mem_rd[7:0];
    endcase
    if (i_off[1]) begin
      w_half = i_mem_rd[31:16];
    end else begin
      w_half = i_mem_rd[15:0];
    end
    case (i_funct3)
      F3_B:    o_data = {{(WORD_W-8){w_byte[7]}}, w_byte};
      F3_H:    o_data = {{(WORD_W-16){w_half[15]}}, w_half};
      F3_BU:   o_data = {{(WORD_W-8){1'b0}}, w_byte};
      F3_HU:   o_data = {{(WORD_W-16){1'b0}}, w_half};
      default: o_data = i_mem_rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: converts core load/store requests into word-addressed
// accesses with byte masks, with a req/busy/done handshake toward the core.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WORD_W           = 32,
  parameter bit SPLIT_UPPER_HALF = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [WORD_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [WORD_W-1:0] o_rdata,
  output logic [WORD_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wd,
  output logic [3:0]        o_mem_wen,
  output logic              o_mem_ren,
  input  logic [WORD_W-1:0] i_mem_rd
);

  lsu_state_e        r_state;
  logic              r_we;
  logic              r_split;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic              r_done;
  logic              r_err;
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wd;
  logic [3:0]        r_mem_wen;
  logic              r_mem_ren;

  logic              w_ok;
  logic              w_split;
  logic [3:0]        w_wen;
  logic [WORD_W-1:0] w_wd;
  logic [WORD_W-1:0] w_load_data;

  assign w_ok = access_ok(i_we, i_funct3, i_addr[1:0]);

  // Store mask and lane replication; only consulted for legal stores.
  always_comb begin
    w_wen   = WEN_NONE;
    w_wd    = i_wdata;
    w_split = 1'b0;
    case (i_funct3)
      F3_B: begin
        w_wen = WEN_B0 << i_addr[1:0];
        w_wd  = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        w_wd = {2{i_wdata[15:0]}};
        if (!i_addr[1]) begin
          w_wen = WEN_LO;
        end else if (SPLIT_UPPER_HALF) begin
          w_wen   = WEN_B2;
          w_split = 1'b1;
        end else begin
          w_wen = WEN_HI;
        end
      end
      F3_W:    w_wen = WEN_ALL;
      default: w_wen = WEN_NONE;
    endcase
  end

  load_extend #(.WORD_W(WORD_W)) u_load_extend (
    .i_mem_rd (i_mem_rd),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  // Control FSM with all core- and memory-facing outputs registered.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_split    <= 1'b0;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      r_mem_wen  <= WEN_NONE;
      r_mem_ren  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_we     <= i_we;
            r_funct3 <= i_funct3;
            r_off    <= i_addr[1:0];
            if (w_ok) begin
              r_state    <= ST_ACCESS;
              r_mem_addr <= {i_addr[WORD_W-1:2], 2'b00};
              if (i_we) begin
                r_mem_wen <= w_wen;
                r_mem_wd  <= w_wd;
                r_split   <= w_split;
              end else begin
                r_mem_ren <= 1'b1;
                r_split   <= 1'b0;
              end
            end else begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (!r_we) begin
            r_mem_ren <= 1'b0;
            r_state   <= ST_RD_WAIT;
          end else if (r_split) begin
            r_mem_wen <= WEN_B3;
            r_state   <= ST_WR_HI;
          end else begin
            r_mem_wen <= WEN_NONE;
            r_done    <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_WR_HI: begin
          r_mem_wen <= WEN_NONE;
          r_done    <= 1'b1;
          r_state   <= ST_RESP;
        end
        ST_RD_WAIT: begin
          r_rdata <= w_load_data;
          r_done  <= 1'b1;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_wen <= WEN_NONE;
          r_mem_ren <= 1'b0;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_rdata    = r_rdata;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_wd   = r_mem_wd;
  assign o_mem_wen  = r_mem_wen;
  assign o_mem_ren  = r_mem_ren;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-maskable memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wd;
  logic [3:0]  o_mem_wen;
  logic        o_mem_ren;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:15];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  always #5 i_clk = ~i_clk;

  load_store_unit #(.WORD_W(32), .SPLIT_UPPER_HALF(1'b1)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_funct3   (i_funct3),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_rdata    (o_rdata),
    .o_mem_addr (o_mem_addr),
    .o_mem_wd   (o_mem_wd),
    .o_mem_wen  (o_mem_wen),
    .o_mem_ren  (o_mem_ren),
    .i_mem_rd   (mem_rd)
  );

  // Synchronous memory: byte-masked writes, read data one cycle after ren.
  always @(posedge i_clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else begin
      for (int b = 0; b < 4; b++)
        if (o_mem_wen[b]) mem[o_mem_addr[5:2]][8*b +: 8] <= o_mem_wd[8*b +: 8];
    end
    if (o_mem_ren) mem_rd <= mem[o_mem_addr[5:2]];
  end

  always @(negedge i_clk) if (o_mem_ren && (o_mem_wen != 4'b0000)) overlap++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE and records the per-cycle memory activity.
  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, output int lat, output logic [3:0] wen1,
                    output logic [3:0] wen2, output logic [31:0] wd1,
                    output logic [31:0] ma1, output int rens, output logic err);
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    lat = 0; rens = 0; wen1 = 4'b0000; wen2 = 4'b0000; wd1 = 32'h0; ma1 = 32'h0; err = 1'b0;
    do begin
      @(negedge i_clk);
      i_req = 1'b0;
      lat++;
      if (o_mem_ren) rens++;
      if (lat == 1) begin wen1 = o_mem_wen; wd1 = o_mem_wd; ma1 = o_mem_addr; end
      if (lat == 2) wen2 = o_mem_wen;
    end while (!o_done && lat < 8);
    err = o_err;
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int lat, rens, dcnt;
    logic [3:0] wen1, wen2, ren_v, busy_v, done_v;
    logic [31:0] wd1, ma1;
    logic err, got;

    i_rstn = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b000;
    i_addr = 32'h0; i_wdata = 32'h0; pre_we = 1'b0; pre_idx = 4'h0; pre_data = 32'h0;
    @(negedge i_clk);
    for (int i = 0; i < 16; i++) begin
      pre_we = 1'b1; pre_idx = 4'(i);
      pre_data = (i == 4) ? 32'h8899AABB : 32'h0;
      @(negedge i_clk);
    end
    pre_we = 1'b0;
    chk("rst_ctrl", 32'({o_busy, o_done, o_err, o_mem_ren, o_mem_wen}), 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_mem", o_mem_addr | o_mem_wd, 32'h0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    op(1'b0, F3_B, 32'h11, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_ren_cycles", 32'(rens), 32'd1);
    chk("lb_wen", 32'(wen1), 32'h0);
    chk("lb_maddr", ma1, 32'h10);
    chk("lb_err", 32'(err), 32'h0);
    chk("lb_rdata", o_rdata, 32'hFFFFFFAA);
    chk("lb_idle", 32'(o_busy), 32'h0);

    op(1'b0, F3_BU, 32'h13, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("lbu_rdata", o_rdata, 32'h00000088);
    op(1'b0, F3_H, 32'h12, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("lh_rdata", o_rdata, 32'hFFFF8899);
    op(1'b0, F3_HU, 32'h10, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("lhu_rdata", o_rdata, 32'h0000AABB);
    op(1'b0, F3_W, 32'h10, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("lw_rdata", o_rdata, 32'h8899AABB);
    chk("lw_lat", 32'(lat), 32'd3);

    op(1'b1, F3_H, 32'h12, 32'h00001234, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("sh_split_lat", 32'(lat), 32'd3);
    chk("sh_split_wen1", 32'(wen1), 32'(4'b0100));
    chk("sh_split_wen2", 32'(wen2), 32'(4'b1000));
    chk("sh_split_wd", wd1, 32'h12341234);
    chk("sh_split_ren", 32'(rens), 32'd0);
    chk("sh_rdata_kept", o_rdata, 32'h8899AABB);
    op(1'b0, F3_W, 32'h10, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("sh_readback", o_rdata, 32'h1234AABB);

    op(1'b1, F3_B, 32'h13, 32'h000000EE, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("sb_wen", 32'(wen1), 32'(4'b1000));
    chk("sb_wd", wd1, 32'hEEEEEEEE);
    chk("sb_lat", 32'(lat), 32'd2);
    op(1'b1, F3_H, 32'h18, 32'h0000ABCD, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("sh_lo_wen", 32'(wen1), 32'(4'b0011));
    chk("sh_lo_wd", wd1, 32'hABCDABCD);
    chk("sh_lo_lat", 32'(lat), 32'd2);
    chk("sh_lo_mem", mem[6], 32'h0000ABCD);
    op(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("sw_wen", 32'(wen1), 32'(4'b1111));
    chk("sw_wd", wd1, 32'hDEADBEEF);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_ren", 32'(rens), 32'd0);
    chk("store_rdata_kept", o_rdata, 32'h1234AABB);

    op(1'b0, F3_W, 32'h11, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("mis_err", 32'(err), 32'h1);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_wen", 32'(wen1), 32'h0);
    chk("mis_ren", 32'(rens), 32'd0);
    chk("mis_rdata_kept", o_rdata, 32'h1234AABB);
    op(1'b0, 3'b011, 32'h10, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("ill_ld_err", 32'(err), 32'h1);
    chk("ill_ld_lat", 32'(lat), 32'd1);
    op(1'b1, F3_BU, 32'h10, 32'h55, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("ill_st_err", 32'(err), 32'h1);
    chk("ill_st_wen", 32'(wen1), 32'h0);
    op(1'b0, F3_W, 32'h10, 32'h0, lat, wen1, wen2, wd1, ma1, rens, err);
    chk("sw_readback", o_rdata, 32'hDEADBEEF);

    // Reset during the upper-byte write of a split halfword store.
    i_req = 1'b1; i_we = 1'b1; i_funct3 = F3_H; i_addr = 32'h16; i_wdata = 32'h00005678;
    @(negedge i_clk);
    i_req = 1'b0;
    chk("rst_sh_wen1", 32'(o_mem_wen), 32'(4'b0100));
    @(negedge i_clk);
    chk("rst_sh_wen2", 32'(o_mem_wen), 32'(4'b1000));
    i_rstn = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({o_busy, o_done, o_err, o_mem_ren, o_mem_wen}), 32'h0);
    chk("midrst_rdata", o_rdata, 32'h0);
    dcnt = 0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (o_done || o_busy) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    chk("midrst_mem", mem[5], 32'h00780000);

    // Request held high across a busy load: re-accepted only after RESP.
    i_req = 1'b1; i_we = 1'b0; i_funct3 = F3_W; i_addr = 32'h10; i_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      ren_v[k] = o_mem_ren; busy_v[k] = o_busy; done_v[k] = o_done;
    end
    chk("b2b_ren", 32'(ren_v), 32'(4'b0001));
    chk("b2b_busy", 32'(busy_v), 32'(4'b0111));
    chk("b2b_done", 32'(done_v), 32'(4'b0100));
    chk("b2b_rdata1", o_rdata, 32'hDEADBEEF);
    @(negedge i_clk);
    i_req = 1'b0;
    chk("b2b_second_ren", 32'({o_busy, o_mem_ren}), 32'h3);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge i_clk);
      if (o_done) got = 1'b1;
    end
    chk("b2b_second_done", 32'(got), 32'h1);
    chk("b2b_rdata2", o_rdata, 32'hDEADBEEF);
    @(negedge i_clk);

    chk("ren_wen_exclusive", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
